// File: rtl/johnson_sched_pkg.sv
// Shared types and helpers for the Johnson phase scheduler: FSM state,
// one-hot phase decode and the Johnson-code legality check.
package johnson_sched_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_e;

  // Phase index = popcount while bit 0 is clear, else 2*width - popcount.
  function automatic logic [2*MAX_W-1:0] phase_decode(input logic [MAX_W-1:0] jc,
                                                      input int             width);
    int ones = 0;
    int idx;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width && jc[i]) ones++;
    end
    idx = jc[0] ? (2 * width - ones) : ones;
    return (2*MAX_W)'(1) << idx;
  endfunction

  // Legal Johnson codes have at most one adjacent-bit transition.
  function automatic logic jc_legal(input logic [MAX_W-1:0] jc,
                                    input int             width);
    int edges = 0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if (i < width - 1 && jc[i] != jc[i+1]) edges++;
    end
    return edges <= 1;
  endfunction

endpackage

// File: rtl/johnson_shift_core.sv
// WIDTH-stage Johnson shift register; clr (to all-zero) wins over adv.
module johnson_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             clr,
  output logic [WIDTH-1:0] jc_out
);

  logic [WIDTH-1:0] jc_q, jc_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    jc_d = jc_q;
    if (clr)      jc_d = '0;
    else if (adv) jc_d = {~jc_q[0], jc_q[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) jc_q <= '0;
    else      jc_q <= jc_d;
  end

  assign jc_out = jc_q;

endmodule

// File: rtl/johnson_phase_scheduler.sv
// Runs a Johnson counter through a programmed number of rotations with
// start/stop/step control. Optional: JOHNSON_SCHED_ILLEGAL_RECOVER_EN.
module johnson_phase_scheduler
  import johnson_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic [CNT_W-1:0]   num_cycles,
  output logic [WIDTH-1:0]   jc_out,
  output logic [2*WIDTH-1:0] phase,
  output logic [CNT_W-1:0]   remaining,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [WIDTH-1:0] LAST_CODE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             err_d;
  logic             adv, clr;
  logic             wrap;

  johnson_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv),
    .clr    (clr),
    .jc_out (jc_out)
  );

  assign wrap = (jc_out == LAST_CODE);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    adv     = 1'b0;
    clr     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          rem_d   = num_cycles;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) state_d = ST_PAUSE;
        else      adv     = 1'b1;
      end
      ST_PAUSE: begin
        if (stop) begin
          clr     = 1'b1;
          rem_d   = '0;
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
        end else if (step) begin
          adv = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Rotation accounting is shared by free advances in RUN and steps in PAUSE.
    if (adv && wrap && rem_q != '0) begin
      if (rem_q == CNT_W'(1)) begin
        rem_d   = '0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        rem_d = rem_q - CNT_W'(1);
      end
    end

`ifdef JOHNSON_SCHED_ILLEGAL_RECOVER_EN
    if (!jc_legal(MAX_W'(jc_out), WIDTH)) begin
      adv     = 1'b0;
      clr     = 1'b1;
      rem_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

`ifdef JOHNSON_SCHED_ILLEGAL_RECOVER_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = err_d;
  assign err        = 1'b0;
`endif

  assign phase     = (2*WIDTH)'(phase_decode(MAX_W'(jc_out), WIDTH));
  assign remaining = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
